// File: rtl/image_fetch_ctrl.sv
// image_fetch_ctrl: read sequencer for the LCD frame memory.
// Walks addresses 0..ADDR_DEPTH-1 once per start_i and issues reads that
// respect the memory read latency. Returned words go into a 2-entry
// first-word-fall-through FIFO, which feeds a valid/ready pixel stream.
// Build option: define IMAGE_FETCH_CONTINUOUS_EN to keep fetching frames
// back to back after the first start_i. Reads then wrap from the last
// address to address 0 with no gap.
module image_fetch_ctrl #(
    parameter int ADDR_DEPTH = 16384,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH),
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic                  pix_valid_o,
    output logic [DATA_WIDTH-1:0] pix_data_o,
    input  logic                  pix_ready_i
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   LAST_PIX  = (ADDR_WIDTH + 1)'(ADDR_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     acc_q, acc_d;
    logic                    done_q, done_d;
    logic                    inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0]   fifo0_q, fifo0_d;
    logic [DATA_WIDTH-1:0]   fifo1_q, fifo1_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              count_q, count_d;

    logic                    pop_s;
    logic                    push_s;
    logic                    rd_en_s;
    logic [2:0]              occ_s;

    // Credit check, FIFO push/pop and pointer/count updates.
    // The pop of the current cycle is credited, so a slot that is being
    // drained right now can be refilled. This gives 1 pixel/clk and can
    // never overflow the two entries.
    always_comb begin
        pop_s      = (count_q != 2'd0) && pix_ready_i;
        occ_s      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        rd_en_s    = (state_q == ST_FETCH) && (occ_s < 3'd2);
        if (RD_LATENCY == 0) begin
            push_s     = rd_en_s;
            inflight_d = 1'b0;
        end else begin
            push_s     = inflight_q;
            inflight_d = rd_en_s;
        end
        fifo0_d  = fifo0_q;
        fifo1_d  = fifo1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            if (wr_ptr_q) begin
                fifo1_d = mem_rd_data_i;
            end else begin
                fifo0_d = mem_rd_data_i;
            end
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
    end

    // Next-state logic for the frame sequencer, read address and pixel counter.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The cycle that shows frame_done_o is idle, but a start there is ignored.
                if (start_i && !done_q) begin
                    state_d = ST_FETCH;
                    addr_d  = {ADDR_WIDTH{1'b0}};
                    acc_d   = {(ADDR_WIDTH + 1){1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (rd_en_s) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d = {ADDR_WIDTH{1'b0}};
`ifdef IMAGE_FETCH_CONTINUOUS_EN
                        state_d = ST_FETCH;
`else
                        state_d = ST_DRAIN;
`endif
                    end else begin
                        addr_d = addr_q + {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};
                    end
                end else begin
                    addr_d = addr_q;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DRAIN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Count accepted pixels. The last one of a frame ends it.
        if ((state_q != ST_IDLE) && pop_s) begin
            if (acc_q == LAST_PIX) begin
                acc_d  = {(ADDR_WIDTH + 1){1'b0}};
                done_d = 1'b1;
`ifndef IMAGE_FETCH_CONTINUOUS_EN
                state_d = ST_IDLE;
`endif
            end else begin
                acc_d = acc_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
        end else begin
            acc_d = acc_d;
        end
    end

    // Sequencer state register; reset also discards any in-flight read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= {ADDR_WIDTH{1'b0}};
            acc_q      <= {(ADDR_WIDTH + 1){1'b0}};
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            acc_q      <= acc_d;
            done_q     <= done_d;
            inflight_q <= inflight_d;
        end
    end

    // Two-entry pixel FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fifo0_q  <= {DATA_WIDTH{1'b0}};
            fifo1_q  <= {DATA_WIDTH{1'b0}};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            fifo0_q  <= fifo0_d;
            fifo1_q  <= fifo1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign frame_done_o  = done_q;
    assign mem_rd_en_o   = rd_en_s;
    assign mem_rd_addr_o = addr_q;
    assign pix_valid_o   = (count_q != 2'd0);
    assign pix_data_o    = rd_ptr_q ? fifo1_q : fifo0_q;

endmodule

// File: tb/tb_image_fetch_ctrl.sv
// Directed bench for image_fetch_ctrl.
// Instance A: 8 words, registered memory (latency 1), words 0x10..0x17.
// Instance B: 5 words, unregistered memory (latency 0), words 0x20..0x24.
module tb_image_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, ready_a = 1'b0, start_b = 1'b0, ready_b = 1'b0;
    logic        busy_a, done_a, rden_a, valid_a;
    logic        busy_b, done_b, rden_b, valid_b;
    logic [2:0]  addr_a, addr_b;
    logic [15:0] rdata_a, rdata_b, data_a, data_b;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    image_fetch_ctrl #(.ADDR_DEPTH(8), .DATA_WIDTH(16), .RD_LATENCY(1)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .busy_o(busy_a),
        .frame_done_o(done_a), .mem_rd_en_o(rden_a), .mem_rd_addr_o(addr_a),
        .mem_rd_data_i(rdata_a), .pix_valid_o(valid_a), .pix_data_o(data_a),
        .pix_ready_i(ready_a));

    image_fetch_ctrl #(.ADDR_DEPTH(5), .DATA_WIDTH(16), .RD_LATENCY(0)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .busy_o(busy_b),
        .frame_done_o(done_b), .mem_rd_en_o(rden_b), .mem_rd_addr_o(addr_b),
        .mem_rd_data_i(rdata_b), .pix_valid_o(valid_b), .pix_data_o(data_b),
        .pix_ready_i(ready_b));

    // Registered memory model for A, combinational memory model for B.
    always @(posedge clk) if (rden_a) rdata_a <= 16'h0010 + {13'd0, addr_a};
    assign rdata_b = 16'h0020 + {13'd0, addr_b};

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (busy_a !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy_a); end
        total++; if (done_a !== 1'b0)  begin bad++; $display("FAIL reset_done got=%0b exp=0", done_a); end
        total++; if (rden_a !== 1'b0)  begin bad++; $display("FAIL reset_rden got=%0b exp=0", rden_a); end
        total++; if (addr_a !== 3'd0)  begin bad++; $display("FAIL reset_addr got=%0d exp=0", addr_a); end
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid_a); end
        total++; if (data_a !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", data_a); end
        total++; if (busy_b !== 1'b0)  begin bad++; $display("FAIL reset_busy_b got=%0b exp=0", busy_b); end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // 8 pixels on consecutive cycles 3..10 after start; done with busy low at 11.
    task automatic test_basic_frame();
        logic        exp_v;
        logic [15:0] exp_d;
        @(negedge clk); start_a = 1'b1; ready_a = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk); start_a = 1'b0; #1;
            exp_v = (k >= 3) && (k <= 10);
            exp_d = 16'h0010 + 16'(k - 3);
            total++; if (valid_a !== exp_v) begin bad++; $display("FAIL basic_valid k=%0d got=%0b exp=%0b", k, valid_a, exp_v); end
            if (exp_v) begin
                total++; if (data_a !== exp_d) begin bad++; $display("FAIL basic_data k=%0d got=%h exp=%h", k, data_a, exp_d); end
            end
            total++; if (done_a !== (k == 11)) begin bad++; $display("FAIL basic_done k=%0d got=%0b exp=%0b", k, done_a, (k == 11)); end
            total++; if (busy_a !== (k <= 10)) begin bad++; $display("FAIL basic_busy k=%0d got=%0b exp=%0b", k, busy_a, (k <= 10)); end
        end
    endtask

    // Ready pattern 1,0,0,1: ordered data, stable stalls, at most 2 outstanding.
    task automatic test_stall_pattern();
        int          n = 0, dones = 0, issued = 0;
        logic        prev_stall = 1'b0;
        logic [15:0] prev_data = 16'h0;
        logic [15:0] exp_d;
        @(negedge clk); start_a = 1'b1; ready_a = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); start_a = 1'b0;
            ready_a = ((c % 4) == 0) || ((c % 4) == 3);
            #1;
            if (prev_stall) begin
                total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL stall_valid c=%0d got=%0b exp=1", c, valid_a); end
                total++; if (data_a !== prev_data) begin bad++; $display("FAIL stall_data c=%0d got=%h exp=%h", c, data_a, prev_data); end
            end
            if (rden_a === 1'b1) issued++;
            if (valid_a && ready_a) begin
                exp_d = 16'h0010 + 16'(n);
                total++; if (data_a !== exp_d) begin bad++; $display("FAIL stall_order n=%0d got=%h exp=%h", n, data_a, exp_d); end
                n++;
            end
            total++; if (issued - n > 2) begin bad++; $display("FAIL stall_credit c=%0d got=%0d exp<=2", c, issued - n); end
            if (done_a === 1'b1) dones++;
            prev_stall = valid_a && !ready_a;
            prev_data  = data_a;
        end
        total++; if (n != 8)        begin bad++; $display("FAIL stall_count got=%0d exp=8", n); end
        total++; if (issued != 8)   begin bad++; $display("FAIL stall_issued got=%0d exp=8", issued); end
        total++; if (dones != 1)    begin bad++; $display("FAIL stall_dones got=%0d exp=1", dones); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL stall_busy_end got=%0b exp=0", busy_a); end
        ready_a = 1'b1;
    endtask

    // Latency 0, depth 5: pixels at cycles 2..6, done at 7, address stays below 5.
    task automatic test_lat0();
        logic        exp_v;
        logic [15:0] exp_d;
        int          dones = 0;
        @(negedge clk); start_b = 1'b1; ready_b = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk); start_b = 1'b0; #1;
            exp_v = (k >= 2) && (k <= 6);
            exp_d = 16'h0020 + 16'(k - 2);
            total++; if (addr_b >= 3'd5) begin bad++; $display("FAIL lat0_addr k=%0d got=%0d exp<5", k, addr_b); end
            total++; if (valid_b !== exp_v) begin bad++; $display("FAIL lat0_valid k=%0d got=%0b exp=%0b", k, valid_b, exp_v); end
            if (exp_v) begin
                total++; if (data_b !== exp_d) begin bad++; $display("FAIL lat0_data k=%0d got=%h exp=%h", k, data_b, exp_d); end
            end
            total++; if (busy_b !== (k <= 6)) begin bad++; $display("FAIL lat0_busy k=%0d got=%0b exp=%0b", k, busy_b, (k <= 6)); end
            if (done_b === 1'b1) dones++;
        end
        total++; if (dones != 1) begin bad++; $display("FAIL lat0_dones got=%0d exp=1", dones); end
    endtask

    // start_i pulsed mid-frame (cycle 5) and on the done cycle (11): both ignored.
    task automatic test_start_ignored();
        int          n = 0, dones = 0;
        logic [15:0] exp_d;
        @(negedge clk); start_a = 1'b1; ready_a = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk); start_a = (k == 5) || (k == 11); #1;
            if (valid_a && ready_a) begin
                exp_d = 16'h0010 + 16'(n);
                total++; if (data_a !== exp_d) begin bad++; $display("FAIL ign_data n=%0d got=%h exp=%h", n, data_a, exp_d); end
                n++;
            end
            if (done_a === 1'b1) dones++;
            total++; if (busy_a !== (k <= 10)) begin bad++; $display("FAIL ign_busy k=%0d got=%0b exp=%0b", k, busy_a, (k <= 10)); end
        end
        start_a = 1'b0;
        total++; if (n != 8)     begin bad++; $display("FAIL ign_count got=%0d exp=8", n); end
        total++; if (dones != 1) begin bad++; $display("FAIL ign_dones got=%0d exp=1", dones); end
    endtask

    // Asynchronous reset after pixel 3 is accepted, then a fresh frame from 0x10.
    task automatic test_async_reset();
        @(negedge clk); start_a = 1'b1; ready_a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); start_a = 1'b0; #1;
        end
        total++; if (data_a !== 16'h0013) begin bad++; $display("FAIL rst_pre_data got=%h exp=0013", data_a); end
        @(negedge clk); #2; rst = 1'b1; #1;
        total++; if (busy_a !== 1'b0)  begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy_a); end
        total++; if (rden_a !== 1'b0)  begin bad++; $display("FAIL rst_rden got=%0b exp=0", rden_a); end
        total++; if (addr_a !== 3'd0)  begin bad++; $display("FAIL rst_addr got=%0d exp=0", addr_a); end
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", valid_a); end
        total++; if (data_a !== 16'h0) begin bad++; $display("FAIL rst_data got=%h exp=0000", data_a); end
        total++; if (done_a !== 1'b0)  begin bad++; $display("FAIL rst_done got=%0b exp=0", done_a); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); start_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); start_a = 1'b0; #1;
            if (k == 3) begin
                total++; if (valid_a !== 1'b1 || data_a !== 16'h0010) begin bad++; $display("FAIL rst_restart0 got=%0b/%h exp=1/0010", valid_a, data_a); end
            end
            if (k == 4) begin
                total++; if (valid_a !== 1'b1 || data_a !== 16'h0011) begin bad++; $display("FAIL rst_restart1 got=%0b/%h exp=1/0011", valid_a, data_a); end
            end
        end
        repeat (12) @(negedge clk);
    endtask

    // Continuous mode: 24 gapless pixels, wrap 7->0, done pulses at 11, 19, 27.
    task automatic test_continuous();
        logic [15:0] exp_d;
        logic [2:0]  last_addr = 3'd0;
        logic        wrap_seen = 1'b0;
        int          dones = 0;
        @(negedge clk); start_a = 1'b1; ready_a = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk); start_a = 1'b0; #1;
            if (k >= 3 && k <= 26) begin
                exp_d = 16'h0010 + 16'((k - 3) % 8);
                total++; if (valid_a !== 1'b1 || data_a !== exp_d) begin bad++; $display("FAIL cont_pix k=%0d got=%0b/%h exp=1/%h", k, valid_a, data_a, exp_d); end
            end
            total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL cont_busy k=%0d got=%0b exp=1", k, busy_a); end
            total++; if (done_a !== (k == 11 || k == 19 || k == 27)) begin bad++; $display("FAIL cont_done k=%0d got=%0b", k, done_a); end
            if (done_a === 1'b1) dones++;
            if (rden_a === 1'b1) begin
                if (addr_a == 3'd0 && last_addr == 3'd7) wrap_seen = 1'b1;
                last_addr = addr_a;
            end
        end
        total++; if (dones != 3)        begin bad++; $display("FAIL cont_dones got=%0d exp=3", dones); end
        total++; if (wrap_seen !== 1'b1) begin bad++; $display("FAIL cont_wrap got=%0b exp=1", wrap_seen); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef IMAGE_FETCH_CONTINUOUS_EN
        test_continuous();
`else
        test_basic_frame();
        test_stall_pattern();
        test_lat0();
        test_start_ignored();
        test_async_reset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
